m_wbfifo_tx: RTL and testbench

- Wishbone classic responder that turns core stores into a 32-bit outbound word stream, for peripherals that consume data at their own pace (UART, SPI, display shifters).
- The midgetv core is the initiator. This block sits beside m_wishbonereg on the same STB/ACK bus and is decoded by a separate address-qualified STB_I.
- Contents: a word FIFO, a status/control register pair and a programmable-latency ACK generator.

---
 rtl/m_wbfifo_tx_pkg.sv | 35 +++
 rtl/m_wbfifo_tx_mem.sv | 72 +++++++
 rtl/m_wbfifo_tx.sv | 138 +++++++++++++
 tb/tb_m_wbfifo_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_wbfifo_tx_pkg.sv
// Shared definitions for the Wishbone transmit FIFO responder: register
// offsets, status/control bit positions, responder state encoding and the
// byte-lane masking helper used when words are pushed.
package m_wbfifo_tx_pkg;

  // Register offsets on ADR_I (word offset within the block)
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;

  // CTRL flush command bit (acts on write, never stored)
  localparam int CTRL_FLUSH = 31;

  // Responder FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Zero every byte lane whose select bit is clear
  function automatic logic [31:0] sel_mask(input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] res;
    res = '0;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? dat[8*b +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/m_wbfifo_tx_mem.sv
// Synchronous word FIFO with MSB-wrap pointers and a registered head word.
// The head register is loaded with the word that will be at the front after
// the current edge, so a push into an empty FIFO shows up on head one cycle
// after it commits, with no combinational path from wdata to head.
module m_wbfifo_tx_mem
  import m_wbfifo_tx_pkg::*;
#(
  parameter int DEPTHLOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [31:0]          wdata,
  input  logic                 pop,
  input  logic                 flush,
  output logic [31:0]          head,
  output logic [DEPTHLOG2:0]   count,
  output logic                 empty,
  output logic                 full
);

  localparam int DEPTH = 1 << DEPTHLOG2;

  logic [31:0]        mem [DEPTH];
  logic [DEPTHLOG2:0] wptr;
  logic [DEPTHLOG2:0] rptr;
  logic [DEPTHLOG2:0] rptr_nxt;
  logic               pop_ok;
  logic               push_ok;

  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  assign full     = (count == (DEPTHLOG2 + 1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign push_ok  = push && !flush && (!full || pop_ok);
  assign rptr_nxt = rptr + {{DEPTHLOG2{1'b0}}, pop_ok};

  // Storage write port
  // NOTE: the storage array has no reset so it can map onto block RAM; only
  // pointers and the head register need a defined reset value.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[DEPTHLOG2-1:0]] <= wdata;
    end
  end

  // Pointers and registered head word
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      head <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      head <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      rptr <= rptr_nxt;
      if (push_ok || pop_ok) begin
        // The word being written becomes the head when nothing else precedes it
        head <= (push_ok && (wptr == rptr_nxt)) ? wdata : mem[rptr_nxt[DEPTHLOG2-1:0]];
      end
    end
  end

endmodule

// File: rtl/m_wbfifo_tx.sv
// Wishbone classic responder that turns core stores into an outbound 32-bit
// word stream. Holds the responder FSM with programmable ACK latency, the
// STATUS/CTRL registers and the watermark interrupt; storage lives in
// m_wbfifo_tx_mem.
module m_wbfifo_tx
  import m_wbfifo_tx_pkg::*;
#(
  parameter int DEPTHLOG2  = 4,
  parameter int WAITSTATES = 1
) (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq_low
);

  logic [1:0]         state;
  logic [2:0]         wcnt;
  logic [15:0]        watermark;
  logic               overflow;
  logic               irq_low_q;
  logic [DEPTHLOG2:0] count;
  logic [15:0]        count16;
  logic               empty;
  logic               full;
  logic               ack;
  logic               wr_data;
  logic               wr_status;
  logic               wr_ctrl;
  logic               pop;
  logic               flush;
  logic [31:0]        rd_data;

  assign ack       = (state == S_ACK);
  assign wr_data   = ack && WE_I && (ADR_I == ADR_DATA);
  assign wr_status = ack && WE_I && (ADR_I == ADR_STATUS);
  assign wr_ctrl   = ack && WE_I && (ADR_I == ADR_CTRL);
  assign flush     = wr_ctrl && DAT_I[CTRL_FLUSH];
  assign tx_valid  = !empty;
  assign pop       = tx_valid && tx_ready;
  assign count16   = 16'(count);

  m_wbfifo_tx_mem #(
    .DEPTHLOG2(DEPTHLOG2)
  ) u_mem (
    .clk   (CLK_I),
    .rst_n (RST_N_I),
    .push  (wr_data),
    .wdata (sel_mask(SEL_I, DAT_I)),
    .pop   (pop),
    .flush (flush),
    .head  (tx_data),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Responder FSM: one ACK per strobe, WAITSTATES idle cycles before it
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (STB_I) begin
            if (WAITSTATES == 0) begin
              state <= S_ACK;
            end else begin
              state <= S_WAIT;
              wcnt  <= 3'(WAITSTATES);
            end
          end
        end
        S_WAIT: begin
          if (!STB_I) begin
            state <= S_IDLE;
          end else if (wcnt == 3'd1) begin
            state <= S_ACK;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_ACK:   state <= S_HOLD;
        S_HOLD:  if (!STB_I) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file side effects commit on the edge that ends the ACK cycle
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      watermark <= '0;
      overflow  <= 1'b0;
      irq_low_q <= 1'b0;
    end else begin
      irq_low_q <= (count16 < watermark);
      if (wr_status && SEL_I[2] && DAT_I[ST_OVF]) begin
        overflow <= 1'b0;
      end else if (wr_data && full && !pop) begin
        overflow <= 1'b1;
      end
      if (wr_ctrl && SEL_I[0]) watermark[7:0]  <= DAT_I[7:0];
      if (wr_ctrl && SEL_I[1]) watermark[15:8] <= DAT_I[15:8];
    end
  end

  // Read mux
  // NOTE: rd_data gets a default before the case so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (ADR_I)
      ADR_STATUS: begin
        rd_data[15:0]    = count16;
        rd_data[ST_EMPTY] = empty;
        rd_data[ST_FULL]  = full;
        rd_data[ST_OVF]   = overflow;
      end
      ADR_CTRL: rd_data = {16'h0000, watermark};
      default:  rd_data = '0;
    endcase
  end

  assign ACK_O   = ack;
  assign DAT_O   = ack ? rd_data : 32'h0;
  assign irq_low = irq_low_q;

endmodule

// File: tb/tb_m_wbfifo_tx.sv
// Self-checking bench for m_wbfifo_tx. Instance dut (WAITSTATES=1) is checked
// every cycle against a queue-based model; instance dut_b (WAITSTATES=3)
// exercises aborted strobes, held strobes and reset during WAIT.
module tb_m_wbfifo_tx;

  localparam int WS   = 1;
  localparam int WS_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rst_n, stb, we, ack, tx_valid, tx_ready, irq_low;
  logic [1:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat, dat_o, tx_data;
  // Instance B signals
  logic        rst_n_b, stb_b, we_b, ack_b, tx_valid_b, tx_ready_b, irq_low_b;
  logic [1:0]  adr_b;
  logic [3:0]  sel_b;
  logic [31:0] dat_b, dat_o_b, tx_data_b;

  m_wbfifo_tx #(.DEPTHLOG2(4), .WAITSTATES(WS)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .ACK_O(ack), .DAT_O(dat_o), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .irq_low(irq_low)
  );

  m_wbfifo_tx #(.DEPTHLOG2(4), .WAITSTATES(WS_B)) dut_b (
    .CLK_I(clk), .RST_N_I(rst_n_b), .STB_I(stb_b), .WE_I(we_b), .ADR_I(adr_b),
    .SEL_I(sel_b), .DAT_I(dat_b), .ACK_O(ack_b), .DAT_O(dat_o_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .irq_low(irq_low_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  logic [31:0] q[$];
  logic        m_ovf;
  logic [15:0] m_wm;
  logic        m_irq;
  logic        c_wr;          // a write commits on the coming edge
  logic [1:0]  c_adr;
  logic [3:0]  c_sel;
  logic [31:0] c_dat;
  logic        do_pop, do_push, do_flush;
  logic        chk_en = 1'b0;
  logic        rand_ready = 1'b0;

  function automatic logic [31:0] lane_mask(input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (!s[0]) r[7:0]   = 8'h00;
    if (!s[1]) r[15:8]  = 8'h00;
    if (!s[2]) r[23:16] = 8'h00;
    if (!s[3]) r[31:24] = 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == 2'd1) begin
      r[15:0] = 16'(q.size());
      r[16]   = (q.size() == 0);
      r[17]   = (q.size() == 16);
      r[18]   = m_ovf;
    end else if (a == 2'd2) begin
      r = {16'h0000, m_wm};
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_wm  = 16'h0;
      m_irq = 1'b0;
    end else begin
      do_pop   = (q.size() > 0) && tx_ready;
      do_push  = 1'b0;
      do_flush = 1'b0;
      m_irq    = (q.size() < int'(m_wm));
      if (c_wr) begin
        case (c_adr)
          2'd0: do_push = 1'b1;
          2'd1: if (c_sel[2] && c_dat[18]) m_ovf = 1'b0;
          2'd2: begin
            if (c_sel[0]) m_wm[7:0]  = c_dat[7:0];
            if (c_sel[1]) m_wm[15:8] = c_dat[15:8];
            do_flush = c_dat[31];
          end
          default: ;
        endcase
      end
      if (do_flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          if (q.size() < 16) q.push_back(lane_mask(c_sel, c_dat));
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Stream and interrupt outputs compared every cycle
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("tx_valid", tx_valid, (q.size() > 0));
      if (q.size() > 0) check("tx_data", tx_data, q[0]);
      check("irq_low", irq_low, m_irq);
    end
  end

  // Random consumer back-pressure
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // One classic bus cycle on instance A; expected ACK timing is fixed by WS
  task automatic bus(input logic w, input logic [1:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic pop_at_ack, output logic [31:0] rd);
    stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    for (int i = 1; i <= WS; i++) begin
      @(posedge clk); #1;
      check("ack_early", ack, 1'b0);
    end
    @(posedge clk); #1;
    check("ack_rise", ack, 1'b1);
    rd = dat_o;
    if (!w) check("rdata", dat_o, model_read(a));
    c_wr = w; c_adr = a; c_sel = s; c_dat = d;
    if (pop_at_ack) tx_ready = 1'b1;
    @(posedge clk); #1;
    c_wr = 1'b0;
    if (pop_at_ack) tx_ready = 1'b0;
    check("ack_single", ack, 1'b0);
    check("dat_idle", dat_o, 32'h0);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  int          acks, first_ack;
  logic [1:0]  ra;
  logic        rw;
  logic [31:0] rdat;
  int          r;

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; tx_ready = 1'b0;
    rst_n_b = 1'b0; stb_b = 1'b0; we_b = 1'b0; adr_b = '0; sel_b = '0; dat_b = '0; tx_ready_b = 1'b0;
    c_wr = 1'b0; c_adr = '0; c_sel = '0; c_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_irq", irq_low, 1'b0);
    check("rst_b_ack", ack_b, 1'b0);
    rst_n = 1'b1; rst_n_b = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // Full-word push and byte-lane masking
    bus(1'b1, 2'd0, 4'hF, 32'hDEADBEEF, 1'b0, rd);
    check("t1_valid", tx_valid, 1'b1);
    check("t1_data", tx_data, 32'hDEADBEEF);
    bus(1'b1, 2'd0, 4'b0101, 32'h11223344, 1'b0, rd);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("t2_masked", tx_data, 32'h00220044);

    // Flush, then overfill by one
    bus(1'b1, 2'd2, 4'hF, 32'h80000000, 1'b0, rd);
    check("flush_empty", tx_valid, 1'b0);
    for (int i = 1; i <= 17; i++) bus(1'b1, 2'd0, 4'hF, 32'(i), 1'b0, rd);
    bus(1'b0, 2'd1, 4'hF, 32'h0, 1'b0, rd);
    check("status_ovf", rd, 32'h00060010);
    bus(1'b1, 2'd1, 4'b0100, 32'h00040000, 1'b0, rd);
    bus(1'b0, 2'd1, 4'hF, 32'h0, 1'b0, rd);
    check("status_w1c", rd, 32'h00020010);

    // Push into a full FIFO while the consumer pops in the same cycle
    bus(1'b1, 2'd0, 4'hF, 32'hA5A5A5A5, 1'b1, rd);
    bus(1'b0, 2'd1, 4'hF, 32'h0, 1'b0, rd);
    check("full_pop_push", rd, 32'h00020010);
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_order", tx_data, (k < 15) ? 32'(k + 2) : 32'hA5A5A5A5);
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check("drained", tx_valid, 1'b0);

    // Watermark interrupt and flush that keeps the watermark
    bus(1'b1, 2'd2, 4'b0011, 32'h00000004, 1'b0, rd);
    for (int i = 0; i < 3; i++) bus(1'b1, 2'd0, 4'hF, $urandom, 1'b0, rd);
    check("irq_below", irq_low, 1'b1);
    bus(1'b1, 2'd0, 4'hF, 32'h0F0F0F0F, 1'b0, rd);
    check("irq_at_wm", irq_low, 1'b0);
    bus(1'b1, 2'd2, 4'hF, 32'h80000004, 1'b0, rd);
    check("wm_flush_valid", tx_valid, 1'b0);
    bus(1'b0, 2'd2, 4'hF, 32'h0, 1'b0, rd);
    check("wm_kept", rd, 32'h00000004);
    bus(1'b0, 2'd1, 4'hF, 32'h0, 1'b0, rd);
    check("wm_status", rd, 32'h00010000);

    // Randomized traffic against the model
    rand_ready = 1'b1;
    repeat (150) begin
      r  = int'($urandom_range(0, 9));
      ra = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      rw = (ra == 2'd0) ? (r < 4) : 1'($urandom_range(0, 1));
      if (ra == 2'd2) rdat = {($urandom_range(0, 5) == 0), 15'($urandom), 16'($urandom_range(0, 18))};
      else rdat = $urandom;
      bus(rw, ra, 4'($urandom_range(0, 15)), rdat, 1'b0, rd);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    tx_ready = 1'b0;

    // Instance B: strobe dropped during WAIT
    stb_b = 1'b1; we_b = 1'b1; adr_b = 2'd0; sel_b = 4'hF; dat_b = 32'h12345678;
    acks = 0;
    repeat (2) begin @(posedge clk); #1; acks += int'(ack_b); end
    stb_b = 1'b0;
    repeat (6) begin @(posedge clk); #1; acks += int'(ack_b); end
    check("b_drop_noack", acks, 0);
    check("b_drop_fifo", tx_valid_b, 1'b0);

    // Instance B: strobe held for 10 cycles gives one ACK at WS_B+1
    stb_b = 1'b1; dat_b = 32'hCAFEF00D; acks = 0; first_ack = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack_b && first_ack < 0) first_ack = i;
      acks += int'(ack_b);
    end
    stb_b = 1'b0;
    repeat (4) begin @(posedge clk); #1; acks += int'(ack_b); end
    check("b_held_one_ack", acks, 1);
    check("b_latency", first_ack, WS_B + 1);
    check("b_held_valid", tx_valid_b, 1'b1);
    check("b_held_data", tx_data_b, 32'hCAFEF00D);

    // Instance B: reset pulsed mid-WAIT
    stb_b = 1'b1; dat_b = 32'h0BADF00D;
    repeat (2) @(posedge clk);
    #3 rst_n_b = 1'b0;
    #1;
    check("b_rst_ack", ack_b, 1'b0);
    check("b_rst_valid", tx_valid_b, 1'b0);
    check("b_rst_data", tx_data_b, 32'h0);
    stb_b = 1'b0;
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    acks = 0;
    repeat (6) begin @(posedge clk); #1; acks += int'(ack_b); end
    check("b_rst_noack", acks, 0);
    check("b_rst_still_empty", tx_valid_b, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
